// File: rtl/des_pkg.sv
// Shared DES key-schedule tables, types and bit-permutation helpers.
// DES numbering is 1-based with bit 1 as the MSB of each vector.
package des_pkg;

  typedef logic [27:0] half_key_t;
  typedef logic [47:0] subkey_t;
  typedef enum logic {IDLE = 1'b0, GEN = 1'b1} state_t;

  localparam int unsigned PC1_TABLE [56] = '{
    57, 49, 41, 33, 25, 17,  9,
     1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27,
    19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,
     7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29,
    21, 13,  5, 28, 20, 12,  4
  };

  localparam int unsigned PC2_TABLE [48] = '{
    14, 17, 11, 24,  1,  5,
     3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8,
    16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55,
    30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53,
    46, 42, 50, 36, 29, 32
  };

  localparam int unsigned SHIFT_SCHED [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

  function automatic logic [55:0] pc1(input logic [63:0] key);
    logic [55:0] cd;
    for (int i = 0; i < 56; i++) cd[55-i] = key[64-PC1_TABLE[i]];
    return cd;
  endfunction

  function automatic subkey_t pc2(input logic [55:0] cd);
    subkey_t sk;
    for (int i = 0; i < 48; i++) sk[47-i] = cd[56-PC2_TABLE[i]];
    return sk;
  endfunction

  function automatic half_key_t rotl28(input half_key_t x, input logic [1:0] n);
    return (n == 2'd2) ? {x[25:0], x[27:26]} : {x[26:0], x[27]};
  endfunction

  function automatic half_key_t rotr28(input half_key_t x, input logic [1:0] n);
    return (n == 2'd2) ? {x[1:0], x[27:2]} : {x[0], x[27:1]};
  endfunction

  function automatic logic [1:0] shift_of(input logic [3:0] idx);
    return 2'(SHIFT_SCHED[idx]);
  endfunction

  // High when any key byte fails odd parity.
  function automatic logic key_parity_bad(input logic [63:0] key);
    logic bad;
    bad = 1'b0;
    for (int b = 0; b < 8; b++) if (!(^key[8*b +: 8])) bad = 1'b1;
    return bad;
  endfunction

endpackage

// File: rtl/des_pc2.sv
// Pure combinational PC-2 permutation: {C,D} (56 bits) to a 48-bit subkey.
module des_pc2
  import des_pkg::*;
(
  input  logic [55:0] cd_i,
  output subkey_t     subkey_o
);

  assign subkey_o = pc2(cd_i);

endmodule

// File: rtl/des_subkey_gen.sv
// DES round-subkey generator: one subkey per valid/ready transfer, encrypt or decrypt order.
// Optional key parity checking is built when DES_SUBKEY_PARITY_EN is defined.
module des_subkey_gen
  import des_pkg::*;
#(
  parameter int KEY_WIDTH    = 64,
  parameter int SUBKEY_WIDTH = 48,
  parameter int NUM_ROUNDS   = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [KEY_WIDTH-1:0]    key,
  input  logic                    decrypt,
  input  logic                    key_valid,
  output logic                    key_ready,
  output logic [SUBKEY_WIDTH-1:0] subkey,
  output logic [3:0]              subkey_round,
  output logic                    subkey_last,
  output logic                    subkey_valid,
  input  logic                    subkey_ready,
  output logic                    parity_err
);

  // Handshakes: a transfer happens on a rising edge where valid && ready;
  // valid never waits on ready, and held outputs stay stable while ready is low.

  localparam logic [3:0] LAST_ROUND = 4'(NUM_ROUNDS - 1);

  state_t      state_q;
  half_key_t   c_q, d_q, c_d, d_d;
  logic        dir_q;
  logic [3:0]  round_q;
  logic [55:0] pc1_cd;
  logic [1:0]  shamt;
  logic        accept;
  subkey_t     pc2_out;

  assign pc1_cd = pc1(key);
  assign accept = key_valid && key_ready;

  // Decrypt walks the schedule backwards, undoing the shift that produced the current round.
  always_comb begin
    shamt = dir_q ? shift_of(4'd15 - round_q) : shift_of(round_q + 4'd1);
    c_d   = c_q;
    d_d   = d_q;
    if (dir_q) begin
      c_d = rotr28(c_q, shamt);
      d_d = rotr28(d_q, shamt);
    end else begin
      c_d = rotl28(c_q, shamt);
      d_d = rotl28(d_q, shamt);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      c_q     <= '0;
      d_q     <= '0;
      dir_q   <= 1'b0;
      round_q <= '0;
    end else begin
      case (state_q)
        IDLE: if (accept) begin
          dir_q   <= decrypt;
          round_q <= '0;
          state_q <= GEN;
          // Full schedule rotates by 28, so the unrotated halves already equal C16/D16.
          if (decrypt) begin
            c_q <= pc1_cd[55:28];
            d_q <= pc1_cd[27:0];
          end else begin
            c_q <= rotl28(pc1_cd[55:28], 2'd1);
            d_q <= rotl28(pc1_cd[27:0], 2'd1);
          end
        end
        GEN: if (subkey_ready) begin
          round_q <= round_q + 4'd1;
          c_q     <= c_d;
          d_q     <= d_d;
          if (round_q == LAST_ROUND) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  des_pc2 u_pc2 (
    .cd_i     ({c_q, d_q}),
    .subkey_o (pc2_out)
  );

  assign key_ready    = (state_q == IDLE);
  assign subkey_valid = (state_q == GEN);
  assign subkey       = subkey_valid ? pc2_out : '0;
  assign subkey_round = round_q;
  assign subkey_last  = subkey_valid && (round_q == LAST_ROUND);

`ifdef DES_SUBKEY_PARITY_EN
  logic parity_err_q;

  always_ff @(posedge clk) begin
    if (rst)         parity_err_q <= 1'b0;
    else if (accept) parity_err_q <= key_parity_bad(key);
  end

  assign parity_err = parity_err_q;
`else
  assign parity_err = 1'b0;
`endif

endmodule
